// File: rtl/mul_err_profiler.sv
// Exhaustive operand sweep driving a multiplier under test, accumulating error metrics.
// Optional overflow counting is enabled by defining MUL_ERR_PROFILER_OVF_EN.
module mul_err_profiler #(
    parameter int WIDTH  = 6,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     mul_in1,
    output logic [WIDTH-1:0]     mul_in2,
    input  logic [2*WIDTH-1:0]   mul_out,
    input  logic                 mul_overflow,
    output logic [2*WIDTH:0]     err_count,
    output logic [4*WIDTH-1:0]   sum_err,
    output logic [2*WIDTH-1:0]   max_err,
    output logic [2*WIDTH:0]     ovf_count
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0]       CNT_MX = 4'(SETTLE - 1);

    state_t               state, state_n;
    logic [3:0]           cnt, cnt_n;
    logic [WIDTH-1:0]     a_n, b_n;
    logic                 busy_n, done_n;
    logic [2*WIDTH:0]     err_count_n;
    logic [4*WIDTH-1:0]   sum_err_n;
    logic [2*WIDTH-1:0]   max_err_n;
    logic [2*WIDTH-1:0]   exact, err;
    logic                 last_pair;

    // Full-width product so no error is ever truncated away
    assign exact = {{WIDTH{1'b0}}, mul_in1} * {{WIDTH{1'b0}}, mul_in2};
    assign err = (exact >= mul_out) ? (exact - mul_out)
                                    : (mul_out - exact);
    assign last_pair = (mul_in1 == '1) && (mul_in2 == '1);

`ifdef MUL_ERR_PROFILER_OVF_EN
    logic [2*WIDTH:0] ovf_count_n;
`else
    logic unused_ovf;
    assign unused_ovf = mul_overflow;
`endif

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        a_n         = mul_in1;
        b_n         = mul_in2;
        busy_n      = busy;
        done_n      = done;
        err_count_n = err_count;
        sum_err_n   = sum_err;
        max_err_n   = max_err;
`ifdef MUL_ERR_PROFILER_OVF_EN
        ovf_count_n = ovf_count;
`endif
        unique case (state)
            IDLE, DONE: begin
                if (abort) begin
                    if (start) state_n = IDLE;
                end else if (start) begin
                    state_n     = DRIVE;
                    cnt_n       = '0;
                    a_n         = '0;
                    b_n         = '0;
                    busy_n      = 1'b1;
                    done_n      = 1'b0;
                    err_count_n = '0;
                    sum_err_n   = '0;
                    max_err_n   = '0;
`ifdef MUL_ERR_PROFILER_OVF_EN
                    ovf_count_n = '0;
`endif
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else if (cnt == CNT_MX) begin
                    state_n = SAMPLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    err_count_n = err_count
                                + {{(2*WIDTH){1'b0}}, (err != '0)};
                    sum_err_n   = sum_err
                                + {{(2*WIDTH){1'b0}}, err};
                    if (err > max_err) max_err_n = err;
`ifdef MUL_ERR_PROFILER_OVF_EN
                    ovf_count_n = ovf_count
                                + {{(2*WIDTH){1'b0}}, mul_overflow};
`endif
                    if (last_pair) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = DRIVE;
                        b_n     = mul_in2 + ONE_W;
                        if (mul_in2 == '1) a_n = mul_in1 + ONE_W;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mul_in1   <= '0;
            mul_in2   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            sum_err   <= '0;
            max_err   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            mul_in1   <= a_n;
            mul_in2   <= b_n;
            busy      <= busy_n;
            done      <= done_n;
            err_count <= err_count_n;
            sum_err   <= sum_err_n;
            max_err   <= max_err_n;
        end
    end

`ifdef MUL_ERR_PROFILER_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_count <= '0;
        else        ovf_count <= ovf_count_n;
    end
`else
    assign ovf_count = '0;
`endif

endmodule

// File: doc/mul_err_profiler.md
Name: mul_err_profiler

Overview:
- Requester-side driver for the multiplier interface: drives operands into a multiplier under test and reads back its product.
- Sweeps every operand pair exhaustively and compares each returned product against the exact product.
- Accumulates error metrics (error count, sum of error distance, max error) for characterising approximate Dadda multipliers.
- Sits in the characterisation harness opposite the multiplier's mul_side.

Parameters:
- WIDTH, 6, operand width in bits; product is 2*WIDTH bits.
- SETTLE, 1, cycles the product is allowed to settle after operands change. Legal range 1..15.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin sweep; sampled only in IDLE or DONE
- abort  input  1  terminate sweep; return to IDLE
- busy  output  1  high while sweep in progress
- done  output  1  high from sweep completion until next accepted start
- mul_in1  output  WIDTH  operand A to multiplier (registered)
- mul_in2  output  WIDTH  operand B to multiplier (registered)
- mul_out  input  2*WIDTH  product returned by multiplier
- mul_overflow  input  1  overflow flag from multiplier
- err_count  output  2*WIDTH+1  pairs with nonzero error
- sum_err  output  4*WIDTH  sum of |exact - mul_out| over all pairs
- max_err  output  2*WIDTH  largest |exact - mul_out| seen
- ovf_count  output  2*WIDTH+1  pairs with mul_overflow high (see Optional Feature)

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: state IDLE. All outputs 0, including busy, done, mul_in1, mul_in2 and all metrics.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE/DONE, start=1 at edge k:
  - clear all metrics and done; set a=0, b=0; busy=1; go to DRIVE.
  - mul_in1/mul_in2 show pair 0 from edge k.
- DRIVE: settle counter counts SETTLE-1 cycles (zero extra cycles when SETTLE=1), then goes to SAMPLE.
- SAMPLE (one cycle):
  - err = |a*b - mul_out|, computed at full 2*WIDTH width with no truncation.
  - err_count += (err != 0); sum_err += err; max_err = max(max_err, err).
  - Metric registers update at the end of this cycle.
  - If a==b==2^WIDTH-1: go to DONE, busy=0, done=1.
  - Otherwise increment b (inner loop); on b wrap to 0, increment a; new operands registered; go to DRIVE.
- Period per pair: P = SETTLE+1 cycles. Pair i is driven on edges k+i*P .. k+(i+1)*P-1.
- done rises at edge k + 2^(2*WIDTH)*P.
- Metrics are stable and valid whenever done=1; they may be read live while busy.
- start while busy: ignored, no restart.
- abort=1 in DRIVE/SAMPLE: next state IDLE, busy=0, done stays 0.
  - Metrics hold their partial values; mul_in1/mul_in2 hold their last values.
  - abort has priority over the SAMPLE update in the same cycle; that pair is not accumulated.
  - abort in IDLE/DONE: no effect.
- start and abort both high in IDLE/DONE: abort wins; stay/go IDLE, metrics not cleared.
- rst_n low mid-sweep: immediate return to reset state regardless of clk.
- Width guards:
  - err_count and ovf_count can reach 2^(2*WIDTH), hence +1 bit.
  - sum_err cannot overflow for any mul_out value.

Optional Feature:
- Macro: MUL_ERR_PROFILER_OVF_EN.
- Defined: in SAMPLE, ovf_count increments when mul_overflow=1; cleared on accepted start and on reset; gated by abort identically to the other metrics.
- Undefined: mul_overflow ignored; ovf_count tied to 0; no ovf counter logic.

Test Plan (all with WIDTH=6, SETTLE=1):
- Exact model (mul_out = in1*in2), start pulse -> done at start edge + 8192 cycles; err_count=0, sum_err=0, max_err=0.
- Model forcing product LSB to 0 -> err_count=1024, sum_err=1024, max_err=1.
- Model mul_out=0 -> err_count=3969, sum_err=4064256, max_err=3969; then start again -> metrics cleared and the same values reproduced.
- start pulsed repeatedly while busy -> single sweep; done timing unchanged. abort at cycle 100 -> busy=0, done=0, metrics nonzero and frozen.
- rst_n low at cycle 3000 -> all outputs 0 asynchronously; fresh start yields full correct results.
- Macro defined, overflow model flags pairs with a=63 -> ovf_count=64. Macro undefined -> ovf_count=0.
